if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, prefetch entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall_i  input  5  StallBus; bit 0 high = IF/ID not accepting.
REQ-006 SHALL have port br_en_i  input  1  redirect request from EX (branch/jump taken).
REQ-007 SHALL have port br_addr_i  input  32  redirect target.
REQ-008 SHALL have port imem_req_o  output  1  fetch request valid.
REQ-009 SHALL have port imem_addr_o  output  32  fetch address.
REQ-010 SHALL have port imem_ack_i  input  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid_i  input  1  response valid; responses in request order.
REQ-012 SHALL have port imem_rdata_i  input  32  response instruction word.
REQ-013 SHALL have port valid_o  output  1  pc_o/ins_o hold a fetched instruction.
REQ-014 SHALL have port pc_o  output  32  PC of head instruction, to if_id_reg pc_i.
REQ-015 SHALL have port ins_o  output  32  head instruction, to if_id_reg ins_i.
REQ-016 SHALL have port fetch_misalign_o  output  1  sticky misaligned-redirect flag.

Function
REQ-017 SHALL keep fetch_pc, resp_pc, FIFO of {pc,ins}, count, outstanding and drop_cnt counters.
REQ-018 SHALL drive imem_req_o high iff count+outstanding < FIFO_DEPTH, br_en_i low, fetch not halted; imem_addr_o = fetch_pc.
REQ-019 SHALL, on imem_req_o & imem_ack_i, increment fetch_pc by 4 (modulo 2^32) and outstanding by 1.
REQ-020 SHALL, on imem_rvalid_i, decrement outstanding; if drop_cnt>0 decrement drop_cnt and discard, else push {resp_pc, imem_rdata_i} and add 4 to resp_pc.
REQ-021 SHALL present FIFO head on pc_o/ins_o with valid_o = (count != 0); when empty, pc_o = 0, ins_o = 32'h0000_0013 (NOP).
REQ-022 SHALL pop head when valid_o & !stall_i[0]; simultaneous push and pop leaves count unchanged.
REQ-023 SHALL never overflow: credit rule REQ-018 guarantees a free slot for every response.
REQ-024 SHALL, on br_en_i (priority over stall and pop), clear FIFO, set fetch_pc and resp_pc to br_addr_i, drop_cnt <= outstanding - imem_rvalid_i, and discard any same-cycle response.
REQ-025 SHALL deassert valid_o the cycle after br_en_i; first target request issues that cycle.
REQ-026 SHALL give latency: response at cycle N -> valid_o at N+1; 1-cycle memory gives redirect at N -> valid_o at N+3.

Reset
REQ-027 SHALL on rst asynchronously set fetch_pc = resp_pc = RESET_PC, count = outstanding = drop_cnt = 0, fetch_misalign_o = 0.
REQ-028 SHALL drive imem_req_o = 0, valid_o = 0, pc_o = 0, ins_o = NOP during reset; responses arriving during reset ignored.
REQ-029 SHALL issue first request at RESET_PC the first cycle after rst deasserts.

Configuration
REQ-030 SHALL honour macro IF_FETCH_ALIGN_CHECK_EN.
REQ-031 With IF_FETCH_ALIGN_CHECK_EN defined: br_addr_i[1:0] != 0 sets fetch_misalign_o, halts requests until next aligned redirect (which clears flag).
REQ-032 Without it: br_addr_i[1:0] forced to 2'b00, fetch_misalign_o tied 0.

Verification
REQ-033 Reset, 1-cycle memory, no stall -> requests 0x0,0x4,0x8; valid_o with pc_o 0x0 two cycles after rst release.
REQ-034 Hold stall_i[0] 10 cycles -> count reaches 4, imem_req_o low, pc_o stays 0x0, no lost words on release.
REQ-035 br_en_i=1, br_addr_i=0x40 with 3 outstanding -> 3 responses dropped, next valid pc_o = 0x40.
REQ-036 br_en_i coincident with imem_rvalid_i and stall_i[0] -> FIFO empty next cycle, response discarded.
REQ-037 Memory with random 0-3 cycle ack/rvalid delay, 1000 instructions -> pc_o sequence strictly +4, ins_o matches image.
REQ-038 With IF_FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> fetch_misalign_o=1, no requests; redirect to 0x80 clears flag.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// A request transfers on a cycle where imem_req_o and imem_ack_i are both high.
// One imem_rvalid_i/imem_rdata_i beat then returns for each transferred request, in request order.
interface if_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// Prefetching instruction fetch stage: credit-limited requests, in-order response FIFO, redirect drop.
// Optional macro IF_FETCH_ALIGN_CHECK_EN flags misaligned redirects and halts fetch until an aligned one.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  stall_i,
  input  logic        br_en_i,
  input  logic [31:0] br_addr_i,
  if_fetch_if.master  imem,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] ins_o,
  output logic        fetch_misalign_o
);
  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fifo_pc  [FIFO_DEPTH];
  logic [31:0]   fifo_ins [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   credit_used;
  logic [31:0]   br_target;
  logic          halted;
  logic          req;
  logic          accept;
  logic          drop;
  logic          push;
  logic          pop;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic misalign_q;
  logic sig_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (br_en_i) begin
      misalign_q <= (br_addr_i[1:0] != 2'b00);
    end
  end

  assign sig_unused       = ^stall_i[4:1];
  assign br_target        = br_addr_i;
  assign halted           = misalign_q;
  assign fetch_misalign_o = misalign_q;
`else
  logic sig_unused;

  assign sig_unused       = ^{stall_i[4:1], br_addr_i[1:0]};
  assign br_target        = {br_addr_i[31:2], 2'b00};
  assign halted           = 1'b0;
  assign fetch_misalign_o = 1'b0;
`endif

  // Every issued request owns a FIFO slot, so a response can always be pushed.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign req         = !rst && !br_en_i && !halted && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign accept      = req && imem.imem_ack_i;
  assign drop        = imem.imem_rvalid_i && (drop_cnt != '0);
  assign push        = imem.imem_rvalid_i && !drop && !br_en_i;
  assign valid_o     = (count != '0);
  assign pop         = valid_o && !stall_i[0] && !br_en_i;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = fetch_pc;
  assign pc_o             = valid_o ? fifo_pc[rd_ptr]  : 32'h0000_0000;
  assign ins_o            = valid_o ? fifo_ins[rd_ptr] : NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (br_en_i) begin
      // Requests still in flight belong to the old stream; their responses get discarded.
      fetch_pc    <= br_target;
      resp_pc     <= br_target;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(imem.imem_rvalid_i);
      drop_cnt    <= outstanding - CW'(imem.imem_rvalid_i);
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(accept) - CW'(imem.imem_rvalid_i);
      if (drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= resp_pc;
      fifo_ins[wr_ptr] <= imem.imem_rdata_i;
    end
  end
endmodule
